// File: rtl/vip_pkg.sv
// vip_pkg: shared FSM state type, frame counter width and counter-width helper for the vip output stage
package vip_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int FRAME_CNT_W = 16;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vip_frame_counter.sv
// vip_frame_counter: x/y pixel position tracking; outputs x_last, y_last for the current pixel and geom_err_event on an eol at the wrong column
module vip_frame_counter
  import vip_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clock,
  input  logic reset,
  input  logic advance,
  input  logic restart,
  input  logic eol,
  output logic x_last,
  output logic y_last,
  output logic geom_err_event
);
  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  always_comb begin
    cur_x = restart ? '0 : x;
    cur_y = restart ? '0 : y;
    x_last = cur_x == XMAX;
    y_last = cur_y == YMAX;
    geom_err_event = advance & eol & ~x_last;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= eol ? '0 : x_last ? cur_x : cur_x + 1'b1;
      y <= eol ? (y_last ? '0 : cur_y + 1'b1) : cur_y;
    end
endmodule

// File: rtl/pixel_fifo_writer.sv
// pixel_fifo_writer: writes the framed pixel stream into the output FIFO with backpressure, geometry checking and frame counting
//   in_valid/in_ready/in_data/in_sof/in_eol: upstream stream; fifo_wrreq/fifo_data/fifo_full: FIFO write port
//   frame_done/frame_count: completion pulse and count; err_geom/err_clr: sticky geometry error and its clear
module pixel_fifo_writer
  import vip_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic                   in_sof,
  input  logic                   in_eol,
  output logic                   fifo_wrreq,
  output logic [DWIDTH-1:0]      fifo_data,
  input  logic                   fifo_full,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_geom,
  input  logic                   err_clr
);
  state_t state, state_nx;
  logic xfer, write, done_ev, err_ev, x_last, y_last, geom_err_event;
  assign in_ready = ~fifo_full;
  vip_frame_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) counter (
    .clock(clock),
    .reset(reset),
    .advance(write),
    .restart(xfer & in_sof),
    .eol(in_eol),
    .x_last(x_last),
    .y_last(y_last),
    .geom_err_event(geom_err_event)
  );
  // stray data in IDLE and sof inside a frame are both geometry errors; the x overflow check covers over-long lines
  always_comb begin
    xfer = in_valid & in_ready;
    write = xfer & (in_sof | state == ACTIVE);
    done_ev = write & in_eol & y_last;
    err_ev = geom_err_event | (write & ~in_eol & x_last) | (xfer & (in_sof ? state == ACTIVE : state == IDLE));
    state_nx = write ? (done_ev ? IDLE : ACTIVE) : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fifo_wrreq <= 1'b0;
      fifo_data <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      err_geom <= 1'b0;
    end else begin
      fifo_wrreq <= write;
      fifo_data <= write ? in_data : fifo_data;
      frame_done <= done_ev;
      frame_count <= frame_count + FRAME_CNT_W'(done_ev);
      err_geom <= err_ev | (err_geom & ~err_clr);
    end
endmodule

// File: tb/tb_pixel_fifo_writer.sv
// tb_pixel_fifo_writer: scoreboard bench for pixel_fifo_writer on a 4x2 image plus a 1x1 instance for frame count wrap
module tb_pixel_fifo_writer;
  logic clock = 0, reset = 1, in_valid = 0, in_sof = 0, in_eol = 0, fifo_full = 0, err_clr = 0;
  logic [7:0] in_data = 0;
  logic in_ready, fifo_wrreq, frame_done, err_geom;
  logic [7:0] fifo_data;
  logic [15:0] frame_count;
  logic reset1 = 1, valid1 = 0;
  logic ready1, wrreq1, done1, err1;
  logic [7:0] data1;
  logic [15:0] count1;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [7:0] data; logic done; int at;} exp_t;
  exp_t sb[$];

  pixel_fifo_writer #(.DWIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .fifo_full(fifo_full), .frame_done(frame_done), .frame_count(frame_count),
    .err_geom(err_geom), .err_clr(err_clr)
  );

  pixel_fifo_writer #(.DWIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
    .clock(clock), .reset(reset1), .in_valid(valid1), .in_ready(ready1), .in_data(8'h5a),
    .in_sof(1'b1), .in_eol(1'b1), .fifo_wrreq(wrreq1), .fifo_data(data1),
    .fifo_full(1'b0), .frame_done(done1), .frame_count(count1),
    .err_geom(err1), .err_clr(1'b0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (fifo_wrreq) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h want no write", fifo_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_data", fifo_data, e.data);
        check("wr_done", frame_done, e.done);
        check("wr_latency", cyc, e.at);
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL done_without_write: got frame_done 1 want 0");
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic e, input logic w, input logic dn, input int stall = 0);
    @(negedge clock);
    in_valid = 1;
    in_data = d;
    in_sof = s;
    in_eol = e;
    for (int i = 0; i < stall; i++) begin
      fifo_full = 1;
      #1 check("ready_low", in_ready, 0);
      @(negedge clock);
    end
    fifo_full = 0;
    #1 check("ready_high", in_ready, 1);
    if (w) sb.push_back('{d, dn, cyc + 1});
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 0;
    in_sof = 0;
    in_eol = 0;
  endtask

  task automatic frame(input logic [7:0] base, input int stall_at = -1);
    for (int i = 0; i < 8; i++)
      send(8'(base + i), i == 0, i == 3 || i == 7, 1, i == 7, i == stall_at ? 3 : 0);
    idle();
  endtask

  task automatic status(input string tag, input logic [15:0] cnt, input logic err);
    repeat (2) @(negedge clock);
    check({tag, "_count"}, frame_count, cnt);
    check({tag, "_err"}, err_geom, err);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clock);
    err_clr = 1;
    @(negedge clock);
    err_clr = 0;
    check({tag, "_clr"}, err_geom, 0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_wrreq"}, fifo_wrreq, 0);
    check({tag, "_data"}, fifo_data, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_count"}, frame_count, 0);
    check({tag, "_err"}, err_geom, 0);
    check({tag, "_ready"}, in_ready, 1);
    fifo_full = 1;
    #1 check({tag, "_ready_full"}, in_ready, 0);
    fifo_full = 0;
  endtask

  initial begin
    fork
      begin : main_seq
        repeat (3) @(negedge clock);
        reset_values("reset");
        @(negedge clock) reset = 0;
        frame(8'h10);
        status("clean", 1, 0);
        frame(8'h10, 2);
        status("backpressure", 2, 0);
        send(8'h20, 1, 0, 1, 0);
        send(8'h21, 0, 0, 1, 0);
        send(8'h22, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) send(8'(8'h23 + i), 0, i == 3, 1, i == 3);
        idle();
        status("short_line", 3, 1);
        clear_err("short_line");
        send(8'h30, 0, 0, 0, 0);
        send(8'h31, 0, 0, 0, 0);
        idle();
        status("stray", 3, 1);
        clear_err("stray");
        err_clr = 1;
        send(8'h32, 0, 0, 0, 0);
        err_clr = 0;
        idle();
        status("set_over_clr", 3, 1);
        clear_err("set_over_clr");
        send(8'h40, 1, 0, 1, 0);
        send(8'h41, 0, 0, 1, 0);
        send(8'h42, 1, 0, 1, 0);
        send(8'h43, 0, 0, 1, 0);
        send(8'h44, 0, 0, 1, 0);
        send(8'h45, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) send(8'(8'h46 + i), 0, i == 3, 1, i == 3);
        idle();
        status("restart", 4, 1);
        clear_err("restart");
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i), i == 0, i == 4, 1, 0);
        for (int i = 0; i < 4; i++) send(8'(8'h75 + i), 0, i == 3, 1, i == 3);
        idle();
        status("long_line", 5, 1);
        clear_err("long_line");
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), i == 0, i == 3, i < 4, 0);
        #1 reset = 1;
        in_valid = 0;
        in_sof = 0;
        in_eol = 0;
        @(negedge clock);
        reset_values("mid_reset");
        @(negedge clock) reset = 0;
        frame(8'h60);
        status("after_reset", 1, 0);
      end
      begin : wrap_seq
        repeat (3) @(negedge clock);
        reset1 = 0;
        valid1 = 1;
        repeat (65535) @(posedge clock);
        @(negedge clock);
        check("wrap_max", count1, 16'hffff);
        @(posedge clock);
        @(negedge clock);
        valid1 = 0;
        check("wrap_zero", count1, 0);
        check("wrap_err", err1, 0);
      end
    join
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
